// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch and the
// data path. DM has priority; fetch is guaranteed a slot after MAX_DM_BURST contested DM grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 2,
  parameter int MAX_DM_BURST = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int CNT_W   = 4;
  localparam int BURST_W = $clog2(MAX_DM_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DM_BURST);
  localparam logic [CNT_W-1:0]   LAT_LOAD  = CNT_W'(MEM_LAT - 1);

  logic [1:0]        state_reg, state_next;
  logic              owner_reg;
  logic              we_reg;
  logic [CNT_W-1:0]  lat_cnt_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic              mem_en_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg;

  logic is_idle, burst_sat, any_gnt, done_if, done_dm;

  assign is_idle   = (state_reg == IDLE);
  assign burst_sat = (burst_cnt_reg == BURST_MAX);

  // DM wins unless fetch is also waiting and DM has used up its burst allowance.
  assign dm_gnt  = is_idle && dm_req && (!if_req || !burst_sat);
  assign if_gnt  = is_idle && if_req && (!dm_req || burst_sat);
  assign any_gnt = if_gnt || dm_gnt;

  assign done_if = (state_reg == DONE) && (owner_reg == OWN_IF);
  assign done_dm = (state_reg == DONE) && (owner_reg == OWN_DM);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_gnt) state_next = ISSUE;
      ISSUE:   state_next = (MEM_LAT > 1) ? WAIT : DONE;
      // The counter value 1 here is the last WAIT cycle: it reaches 0 as DONE is entered.
      WAIT:    if (lat_cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      we_reg        <= 1'b0;
      lat_cnt_reg   <= '0;
      burst_cnt_reg <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mem_en_reg <= any_gnt;
      mem_we_reg <= dm_gnt && dm_we;

      if (any_gnt) begin
        mem_addr_reg  <= dm_gnt ? dm_addr : if_addr;
        mem_wdata_reg <= dm_wdata;
        owner_reg     <= dm_gnt ? OWN_DM : OWN_IF;
        we_reg        <= dm_gnt && dm_we;
      end

      if (state_reg == ISSUE) begin
        lat_cnt_reg <= LAT_LOAD;
      end else if (state_reg == WAIT) begin
        lat_cnt_reg <= lat_cnt_reg - CNT_W'(1);
      end

      if (dm_gnt && if_req) begin
        if (!burst_sat) burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
      end else if (if_gnt || (is_idle && !if_req)) begin
        burst_cnt_reg <= '0;
      end

      if (done_if) if_rdata_reg <= mem_rdata;
      if (done_dm && !we_reg) dm_rdata_reg <= mem_rdata;
    end
  end

  // Read data bypasses the holding register in the completion cycle itself.
  assign if_rvalid = done_if;
  assign dm_done   = done_dm;
  assign if_rdata  = done_if ? mem_rdata : if_rdata_reg;
  assign dm_rdata  = (done_dm && !we_reg) ? mem_rdata : dm_rdata_reg;

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = !is_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants, memory
// strobes and completions; a second instance covers the single-cycle-latency build.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [11:0] if_addr = '0, dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_done, mem_en, mem_we, busy;
  logic [15:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  logic        if_req_l1 = 1'b0;
  logic [11:0] if_addr_l1 = '0;
  logic        zero_b = 1'b0;
  logic [11:0] zero_a = '0;
  logic [15:0] zero_d = '0;
  logic        if_gnt_l1, if_rvalid_l1, dm_gnt_l1, dm_done_l1, mem_en_l1, mem_we_l1, busy_l1;
  logic [15:0] if_rdata_l1, dm_rdata_l1, mem_wdata_l1;
  logic [15:0] rd_l1 = '0;
  logic [11:0] mem_addr_l1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(LAT), .MAX_DM_BURST(MAXB)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(1), .MAX_DM_BURST(MAXB)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_l1), .if_addr(if_addr_l1), .if_gnt(if_gnt_l1), .if_rvalid(if_rvalid_l1),
    .if_rdata(if_rdata_l1),
    .dm_req(zero_b), .dm_we(zero_b), .dm_addr(zero_a), .dm_wdata(zero_d),
    .dm_gnt(dm_gnt_l1), .dm_done(dm_done_l1), .dm_rdata(dm_rdata_l1),
    .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1),
    .mem_rdata(rd_l1), .busy(busy_l1)
  );

  // Memory macro models: unrelated cycles return random junk so stale captures are exposed.
  logic [15:0] tb_mem  [0:4095];
  logic [15:0] ref_mem [0:4095];
  logic [15:0] rd_pipe [0:1];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? tb_mem[mem_addr] : 16'($urandom);
    rd_pipe[1] <= rd_pipe[0];
    rd_l1      <= mem_en_l1 ? {4'hC, mem_addr_l1} : 16'h0;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction-level reference state.
  int          free_at = 0;
  int          burst = 0;
  bit          pend_valid = 1'b0;
  int          pend_issue = 0, pend_done = 0;
  bit          pend_dm = 1'b0, pend_we = 1'b0;
  logic [11:0] pend_addr = '0;
  logic [15:0] pend_wdata = '0, pend_rdata = '0;
  logic [15:0] held_if = '0, held_dm = '0;
  bit          if_gnt_q = 1'b0, dm_gnt_q = 1'b0;
  logic [7:0]  seq = '0;
  int          nseq = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic raise_if();
    if_req  = 1'b1;
    if_addr = 12'($urandom_range(0, 31));
  endtask

  task automatic raise_dm();
    dm_req   = 1'b1;
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = 12'($urandom_range(0, 31));
    dm_wdata = 16'($urandom);
  endtask

  task automatic model_reset();
    free_at    = 0;
    burst      = 0;
    pend_valid = 1'b0;
    held_if    = '0;
    held_dm    = '0;
    if_gnt_q   = 1'b0;
    dm_gnt_q   = 1'b0;
  endtask

  task automatic evaluate();
    bit idle, e_if, e_dm, e_rv, e_dd;
    logic [15:0] e_ifd, e_dmd;
    idle = (cyc >= free_at);
    e_if = 1'b0;
    e_dm = 1'b0;
    if (idle) begin
      if (dm_req && (!if_req || burst < MAXB)) e_dm = 1'b1;
      else if (if_req) e_if = 1'b1;
    end
    check("if_gnt", if_gnt, e_if);
    check("dm_gnt", dm_gnt, e_dm);
    check("busy", busy, !idle);

    if (pend_valid && cyc == pend_issue) begin
      check("mem_en", mem_en, 1);
      check("mem_we", mem_we, pend_we);
      check("mem_addr", mem_addr, pend_addr);
      if (pend_we) check("mem_wdata", mem_wdata, pend_wdata);
    end else begin
      check("mem_en_idle", mem_en, 0);
      check("mem_we_idle", mem_we, 0);
    end

    e_rv  = pend_valid && cyc == pend_done && !pend_dm;
    e_dd  = pend_valid && cyc == pend_done && pend_dm;
    e_ifd = e_rv ? pend_rdata : held_if;
    e_dmd = (e_dd && !pend_we) ? pend_rdata : held_dm;
    check("if_rvalid", if_rvalid, e_rv);
    check("dm_done", dm_done, e_dd);
    check("if_rdata", if_rdata, e_ifd);
    check("dm_rdata", dm_rdata, e_dmd);
    held_if = e_ifd;
    held_dm = e_dmd;
    if (e_rv || e_dd)
      $display("txn done %s we=%0d addr=%h data=%h cyc=%0d", pend_dm ? "DM" : "IF",
               pend_we, pend_addr, pend_we ? pend_wdata : pend_rdata, cyc);

    if (e_dm && if_req) burst = (burst < MAXB) ? burst + 1 : MAXB;
    else if (e_if || (idle && !if_req)) burst = 0;

    if (e_if || e_dm) begin
      pend_valid = 1'b1;
      pend_issue = cyc + 1;
      pend_done  = cyc + 1 + LAT;
      free_at    = cyc + LAT + 2;
      pend_dm    = e_dm;
      pend_we    = e_dm && dm_we;
      pend_addr  = e_dm ? dm_addr : if_addr;
      pend_wdata = dm_wdata;
      pend_rdata = ref_mem[pend_addr];
      if (pend_we) ref_mem[pend_addr] = pend_wdata;
      if (nseq < 8) begin
        seq = {seq[6:0], e_dm};
        nseq++;
      end
    end
    if_gnt_q = if_gnt;
    dm_gnt_q = dm_gnt;
  endtask

  // mode 0: random requests, 1: both requesters always pending, 2: only the forced ones.
  task automatic step(input int mode, input bit rq_if, input bit rq_dm);
    @(posedge clk);
    #1;
    cyc++;
    if (if_gnt_q) if_req = 1'b0;
    if (dm_gnt_q) dm_req = 1'b0;
    if (!if_req && (rq_if || mode == 1 || (mode == 0 && $urandom_range(0, 3) == 0))) raise_if();
    if (!dm_req && (rq_dm || mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0))) raise_dm();
    @(negedge clk);
    evaluate();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      tb_mem[a]  = 16'($urandom);
      ref_mem[a] = tb_mem[a];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_gnts", {if_gnt, dm_gnt}, 0);
    check("rst_strobes", {if_rvalid, dm_done}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Continuous contention: DM gets three slots, then fetch.
    repeat (32) step(1, 1'b0, 1'b0);
    check("contention_seq", seq, 8'hEE);
    repeat (12) step(2, 1'b0, 1'b0);

    // DM request raised while a fetch is in flight waits for IDLE.
    step(2, 1'b1, 1'b0);
    step(2, 1'b0, 1'b1);
    repeat (6) step(2, 1'b0, 1'b0);

    repeat (600) step(0, 1'b0, 1'b0);
    repeat (12) step(2, 1'b0, 1'b0);

    // Reset asserted during WAIT abandons the access.
    step(2, 1'b1, 1'b0);
    step(2, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("arst_strobes", {if_rvalid, dm_done, if_gnt, dm_gnt}, 0);
    check("arst_rdata", {if_rdata, dm_rdata}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (6) step(2, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1);
    repeat (6) step(2, 1'b0, 1'b0);

    // Single-cycle latency build: no WAIT state.
    @(posedge clk);
    #1;
    if_req_l1  = 1'b1;
    if_addr_l1 = 12'h03C;
    @(negedge clk);
    check("l1_gnt", if_gnt_l1, 1);
    @(posedge clk);
    #1 if_req_l1 = 1'b0;
    @(negedge clk);
    check("l1_mem_en", mem_en_l1, 1);
    check("l1_rvalid_t1", if_rvalid_l1, 0);
    @(negedge clk);
    check("l1_rvalid_t2", if_rvalid_l1, 1);
    check("l1_rdata", if_rdata_l1, 16'hC03C);
    @(negedge clk);
    check("l1_rvalid_t3", if_rvalid_l1, 0);
    check("l1_busy_t3", busy_l1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
